// File: rtl/reg_bank_dumper.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_dumper
// Brief    : Walks every register of the bank and streams each word out as
//            bytes, least-significant byte first, in ascending address order.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_dumper #(
  parameter int BANK_SIZE   = 32,
  parameter int ADDR_LENGTH = 5,
  parameter int DATA_LENGTH = 32,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic [ADDR_LENGTH-1:0] o_rd_addr,
  input  logic [DATA_LENGTH-1:0] i_rd_data,
  output logic [BYTE_WIDTH-1:0]  o_byte,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int BPW   = DATA_LENGTH / BYTE_WIDTH;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [IDX_W-1:0]       c_last_idx  = IDX_W'(BPW - 1);
  localparam logic [ADDR_LENGTH-1:0] c_last_addr = ADDR_LENGTH'(BANK_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_LENGTH-1:0] rd_addr_q, rd_addr_d;
  logic [BYTE_WIDTH-1:0]  byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_LENGTH-1:0] word_q, word_d;

  logic                   w_xfer;
  logic [DATA_LENGTH-1:0] w_word_shifted;

  assign w_xfer         = valid_q & i_byte_ready;
  // Byte following the one currently presented, taken from the latched word.
  assign w_word_shifted = word_q >> (BYTE_WIDTH * (int'(idx_q) + 1));

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    word_d    = word_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rd_addr_d = '0;
          busy_d    = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        word_d  = i_rd_data;
        byte_d  = i_rd_data[BYTE_WIDTH-1:0];
        idx_d   = '0;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (w_xfer) begin
          if (idx_q != c_last_idx) begin
            idx_d  = idx_q + IDX_W'(1);
            byte_d = w_word_shifted[BYTE_WIDTH-1:0];
          end else if (rd_addr_q != c_last_addr) begin
            valid_d   = 1'b0;
            rd_addr_d = rd_addr_q + ADDR_LENGTH'(1);
            state_d   = S_LOAD;
          end else begin
            // Address is held at the last register: no wrap after the dump.
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
    end
  end

  assign o_rd_addr    = rd_addr_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_dumper
// Brief    : Self-checking bench for reg_bank_dumper against a byte-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  byte_o;
  logic        valid;
  logic        ready = 1'b1;
  logic        busy;
  logic        done;

  logic        start4 = 1'b0;
  logic [1:0]  rd_addr4;
  logic [31:0] rd_data4;
  logic [7:0]  byte4;
  logic        valid4;
  logic        busy4;
  logic        done4;

  logic [31:0] bank [32];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] acc_q[$];
  logic [1:0] addr4_q[$];
  logic [7:0] b4_q[$];

  int  start_cyc = 0, done_cyc = 0, last_xfer_cyc = 0;
  int  start_cnt = 0, done_cnt = 0, done4_cnt = 0;
  bit  ready_random = 1'b0;
  bit  stall_pend = 1'b0, prev_done = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  assign rd_data  = bank[rd_addr];
  assign rd_data4 = bank[{3'b000, rd_addr4}];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 ready = ready_random ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  reg_bank_dumper u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(start),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_byte(byte_o), .o_byte_valid(valid), .i_byte_ready(ready),
    .o_busy(busy), .o_done(done)
  );

  reg_bank_dumper #(.BANK_SIZE(4), .ADDR_LENGTH(2)) u_dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_start(start4),
    .o_rd_addr(rd_addr4), .i_rd_data(rd_data4),
    .o_byte(byte4), .o_byte_valid(valid4), .i_byte_ready(1'b1),
    .o_busy(busy4), .o_done(done4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: a dump request seen while idle queues every byte of the bank.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_pend = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (valid && !busy) chk("valid_outside_busy", 32'(valid), 32'd0);
      if (stall_pend) begin
        chk("stall_hold_byte", 32'(byte_o), 32'(stall_byte));
        chk("stall_hold_valid", 32'(valid), 32'd1);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(byte_o), 32'hFFFF_FFFF);
        else chk("byte", 32'(byte_o), 32'(exp_q.pop_front()));
        acc_q.push_back(byte_o);
        if (exp_q.size() == 0) last_xfer_cyc = cyc + 1;
      end
      stall_pend = valid && !ready;
      stall_byte = byte_o;
      if (done) begin
        chk("done_after_last", 32'(exp_q.size()), 32'd0);
        chk("done_edge", cyc, last_xfer_cyc);
        chk("done_busy", 32'(busy), 32'd1);
        if (!ready_random) chk("dump_latency", cyc - start_cyc, 32'd160);
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_done) chk("post_done_idle", {30'd0, busy, done}, 32'd0);
      prev_done = done;
      if (start && !busy) begin
        start_cyc = cyc + 1;
        start_cnt++;
        for (int a = 0; a < 32; a++)
          for (int k = 0; k < 4; k++)
            exp_q.push_back(8'((bank[a] >> (8 * k)) & 32'hFF));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid4) begin
        addr4_q.push_back(rd_addr4);
        b4_q.push_back(byte4);
      end
      if (done4) done4_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = done_cnt;
    int k = 0;
    while (done_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", 32'(done_cnt != n0), 32'd1);
  endtask

  task automatic check_pattern(input string tag);
    chk({tag, "_count"}, 32'(acc_q.size()), 32'd128);
    if (acc_q.size() == 128) begin
      chk({tag, "_b0"}, 32'(acc_q[0]), 32'h00);
      chk({tag, "_b3"}, 32'(acc_q[3]), 32'hA5);
      chk({tag, "_b4"}, 32'(acc_q[4]), 32'h01);
      chk({tag, "_b124"}, 32'(acc_q[124]), 32'h1F);
      chk({tag, "_b127"}, 32'(acc_q[127]), 32'hA5);
    end
  endtask

  initial begin
    int n0, s0, k;
    for (int a = 0; a < 32; a++) bank[a] = 32'hA500_0000 | 32'(a);

    // Reset state
    #12;
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_byte", 32'(byte_o), 32'd0);
    chk("rst_flags", {29'd0, valid, busy, done}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Full dump, ready tied high
    acc_q.delete();
    pulse_start();
    wait_done(400);
    check_pattern("full");

    // Backpressure
    ready_random = 1'b1;
    acc_q.delete();
    pulse_start();
    wait_done(3000);
    check_pattern("bp");
    ready_random = 1'b0;
    repeat (3) @(posedge clk);

    // Byte order
    bank[0] = 32'h1234_5678;
    acc_q.delete();
    pulse_start();
    wait_done(400);
    if (acc_q.size() >= 4) begin
      chk("order_b0", 32'(acc_q[0]), 32'h78);
      chk("order_b1", 32'(acc_q[1]), 32'h56);
      chk("order_b2", 32'(acc_q[2]), 32'h34);
      chk("order_b3", 32'(acc_q[3]), 32'h12);
    end else chk("order_count", 32'(acc_q.size()), 32'd4);
    bank[0] = 32'hA500_0000;

    // Start held high across a dump
    acc_q.delete();
    s0 = start_cnt;
    @(posedge clk); #1 start = 1'b1;
    wait_done(400);
    chk("held_one_dump", 32'(acc_q.size()), 32'd128);
    k = 0;
    while (start_cnt < s0 + 2 && k < 10) begin @(negedge clk); k++; end
    chk("held_restart", 32'(start_cnt - s0), 32'd2);
    chk("held_gap", start_cyc - done_cyc, 32'd2);
    @(posedge clk); #1 start = 1'b0;
    wait_done(400);
    repeat (3) @(posedge clk);
    #1 chk("held_idle_after", 32'(busy), 32'd0);

    // Asynchronous reset mid-dump at word 7, byte 2
    acc_q.delete();
    pulse_start();
    k = 0;
    while (acc_q.size() < 30 && k < 400) begin @(posedge clk); #1; k++; end
    chk("mid_byte_pre", 32'(byte_o), 32'h00);
    chk("mid_addr_pre", 32'(rd_addr), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rd_addr), 32'd0);
    chk("mid_rst_flags", {29'd0, valid, busy, done}, 32'd0);
    chk("mid_rst_byte", 32'(byte_o), 32'd0);
    n0 = done_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_done", 32'(done_cnt), 32'(n0));
    chk("mid_idle", 32'(busy), 32'd0);

    // Last-address boundary with a 4-register bank
    for (int a = 0; a < 4; a++) bank[a] = 32'hA500_0000 | 32'(a);
    addr4_q.delete();
    b4_q.delete();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    k = 0;
    while (done4_cnt == 0 && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(posedge clk);
    #1;
    chk("b4_count", 32'(b4_q.size()), 32'd16);
    chk("b4_done", 32'(done4_cnt), 32'd1);
    chk("b4_addr_hold", 32'(rd_addr4), 32'd3);
    if (b4_q.size() == 16) begin
      for (int i = 0; i < 16; i += 5) chk("b4_addr_seq", 32'(addr4_q[i]), 32'(i / 4));
      chk("b4_addr_last", 32'(addr4_q[15]), 32'd3);
      chk("b4_byte12", 32'(b4_q[12]), 32'h03);
      chk("b4_byte15", 32'(b4_q[15]), 32'hA5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
